// File: rtl/prga.sv
// ---------------------------------------------------------------------------
// prga -- RC4 pseudo-random generation stage
//
// Runs after the KSA stage has scrambled the S RAM. It reads the
// length-prefixed ciphertext ROM, generates one keystream byte per message
// byte while swapping S in place, and writes the length-prefixed plaintext
// into the plaintext RAM. Every message byte takes exactly six cycles.
//
// Optional build macro: PRGA_VALID_CHECK_EN
//   When defined, each plaintext byte must be 'a'..'z' or a space. The first
//   byte outside that set is not written, raises the sticky 'invalid' flag and
//   ends the run early. When undefined, 'invalid' is tied low and every byte
//   is written.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   rdy      out  high only while idle; a start request is accepted then
//   en       in   start pulse, sampled only while rdy=1
//   s_addr   out  S RAM address
//   s_dout   in   S RAM read data, valid one cycle after the address
//   s_din    out  S RAM write data
//   s_wren   out  S RAM write enable
//   ct_addr  out  ciphertext ROM address
//   ct_dout  in   ciphertext ROM read data, one-cycle latency
//   pt_addr  out  plaintext RAM address
//   pt_din   out  plaintext RAM write data
//   pt_wren  out  plaintext RAM write enable
//   invalid  out  early-abort flag (see macro above)
// ---------------------------------------------------------------------------
module prga (
  input  logic       clk,
  input  logic       rst_n,
  output logic       rdy,
  input  logic       en,
  output logic [7:0] s_addr,
  input  logic [7:0] s_dout,
  output logic [7:0] s_din,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_dout,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_din,
  output logic       pt_wren,
  output logic       invalid
);

  typedef enum logic [3:0] {
    IDLE,
    LEN_RD,
    LEN_WR,
    RD_I,
    RD_J,
    WR_I,
    WR_J,
    RD_F,
    WR_PT
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] k_q, k_d;
  logic [7:0] j_q, j_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;

  // Keystream byte S[si+sj] arrives on s_dout in WR_PT, together with the
  // ciphertext byte ct[k] that was addressed in RD_F.
  logic [7:0] ptByte;
  logic       byteValid;

  assign ptByte = s_dout ^ ct_dout;

`ifdef PRGA_VALID_CHECK_EN
  logic invalid_q;

  assign byteValid = ((ptByte >= 8'h61) && (ptByte <= 8'h7A)) || (ptByte == 8'h20);

  // Sticky abort flag: cleared only when a new run is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      invalid_q <= 1'b0;
    end else if ((state_q == IDLE) && en) begin
      invalid_q <= 1'b0;
    end else if ((state_q == WR_PT) && !byteValid) begin
      invalid_q <= 1'b1;
    end
  end

  assign invalid = invalid_q;
`else
  assign byteValid = 1'b1;
  assign invalid   = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= 8'h00;
      k_q     <= 8'h00;
      j_q     <= 8'h00;
      si_q    <= 8'h00;
      sj_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      k_q     <= k_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  // Next-state and register-update logic. The k==len test happens before
  // the increment, so a 255-byte message never wraps k.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    k_d     = k_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          state_d = LEN_RD;
          j_d     = 8'h00;
          k_d     = 8'h01;
        end
      end
      LEN_RD: state_d = LEN_WR;
      LEN_WR: begin
        len_d   = ct_dout;
        state_d = (ct_dout == 8'h00) ? IDLE : RD_I;
      end
      RD_I: state_d = RD_J;
      RD_J: begin
        si_d    = s_dout;
        j_d     = j_q + s_dout;
        state_d = WR_I;
      end
      WR_I: begin
        sj_d    = s_dout;
        state_d = WR_J;
      end
      WR_J: state_d = RD_F;
      RD_F: state_d = WR_PT;
      WR_PT: begin
        if (!byteValid || (k_q == len_q)) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + 8'h01;
          state_d = RD_I;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-port outputs decoded from the state. When i==j the two swap
  // writes hit the same location with the same value, which is harmless.
  always_comb begin
    rdy     = 1'b0;
    s_addr  = 8'h00;
    s_din   = 8'h00;
    s_wren  = 1'b0;
    ct_addr = 8'h00;
    pt_addr = 8'h00;
    pt_din  = 8'h00;
    pt_wren = 1'b0;
    unique case (state_q)
      IDLE:   rdy = 1'b1;
      LEN_RD: ct_addr = 8'h00;
      LEN_WR: begin
        pt_addr = 8'h00;
        pt_din  = ct_dout;
        pt_wren = 1'b1;
      end
      RD_I:   s_addr = k_q;
      RD_J:   s_addr = j_q + s_dout;
      WR_I: begin
        s_addr = k_q;
        s_din  = s_dout;
        s_wren = 1'b1;
      end
      WR_J: begin
        s_addr = j_q;
        s_din  = si_q;
        s_wren = 1'b1;
      end
      RD_F: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
      end
      WR_PT: begin
        pt_addr = k_q;
        pt_din  = ptByte;
        pt_wren = byteValid;
      end
      default: rdy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_prga.sv
// ---------------------------------------------------------------------------
// tb_prga -- self-checking bench for the RC4 PRGA stage
//
// Models the S RAM, ciphertext ROM and plaintext RAM (synchronous read),
// runs a table of directed vectors followed by randomized messages, and
// compares the DUT against a plain-arithmetic RC4 reference model.
// ---------------------------------------------------------------------------
module tb_prga;

`ifdef PRGA_VALID_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rdy;
  logic       en;
  logic [7:0] s_addr, s_dout, s_din;
  logic       s_wren;
  logic [7:0] ct_addr, ct_dout;
  logic [7:0] pt_addr, pt_din;
  logic       pt_wren;
  logic       invalid;

  always #5 clk = ~clk;

  prga dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rdy     (rdy),
    .en      (en),
    .s_addr  (s_addr),
    .s_dout  (s_dout),
    .s_din   (s_din),
    .s_wren  (s_wren),
    .ct_addr (ct_addr),
    .ct_dout (ct_dout),
    .pt_addr (pt_addr),
    .pt_din  (pt_din),
    .pt_wren (pt_wren),
    .invalid (invalid)
  );

  // Memories and the staging arrays they are bulk-loaded from.
  logic [7:0] sMem[256], ctMem[256], ptMem[256];
  logic [7:0] sStage[256], ctStage[256], ptStage[256];
  logic [7:0] sDoutQ, ctDoutQ;
  logic       loadReq, cntClr;
  int         sWrCnt, ptWrCnt;

  assign s_dout  = sDoutQ;
  assign ct_dout = ctDoutQ;

  // Synchronous-read memory models plus write-pulse counters.
  always @(posedge clk) begin
    if (loadReq) begin
      for (int a = 0; a < 256; a++) begin
        sMem[a]  <= sStage[a];
        ctMem[a] <= ctStage[a];
        ptMem[a] <= ptStage[a];
      end
    end else begin
      if (s_wren)  sMem[s_addr]   <= s_din;
      if (pt_wren) ptMem[pt_addr] <= pt_din;
    end
    sDoutQ  <= sMem[s_addr];
    ctDoutQ <= ctMem[ct_addr];
    if (cntClr) begin
      sWrCnt  <= 0;
      ptWrCnt <= 0;
    end else begin
      if (s_wren)  sWrCnt  <= sWrCnt + 1;
      if (pt_wren) ptWrCnt <= ptWrCnt + 1;
    end
  end

  // Directed vector table.
  typedef struct {
    bit                keyS;
    int                nCt;
    logic [0:10][7:0]  ct;
    int                nPt;
    logic [0:10][7:0]  pt;
    int                cycles;
    bit                inv;
  } vec_t;

  vec_t tbl[9];

  int vectors = 0;
  int miscompares = 0;

  // Reference model results.
  logic [7:0] mS[256], expPt[256], ks[256];
  int         expProcessed;
  bit         expInv;

  function automatic bit isPrintable(input logic [7:0] b);
    return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // RC4 generation written directly from the algorithm on plain arrays.
  task automatic refModel(input bit check);
    int len, i, j;
    logic [7:0] t, k8, b;
    for (int a = 0; a < 256; a++) begin
      mS[a]    = sStage[a];
      expPt[a] = ptStage[a];
    end
    len          = int'(ctStage[0]);
    expPt[0]     = ctStage[0];
    expProcessed = 0;
    expInv       = 1'b0;
    j            = 0;
    for (int n = 1; n <= len; n++) begin
      i     = n;
      j     = (j + int'(mS[i])) % 256;
      t     = mS[i];
      mS[i] = mS[j];
      mS[j] = t;
      k8    = mS[(int'(mS[i]) + int'(mS[j])) % 256];
      b     = k8 ^ ctStage[n];
      expProcessed++;
      if (check && !isPrintable(b)) begin
        expInv = 1'b1;
        break;
      end
      expPt[n] = b;
    end
  endtask

  task automatic loadS(input int kind);
    logic [7:0] key[3];
    logic [7:0] t;
    int j, r;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;
    for (int a = 0; a < 256; a++) sStage[a] = 8'(a);
    if (kind == 1) begin
      j = 0;
      for (int i = 0; i < 256; i++) begin
        j = (j + int'(sStage[i]) + int'(key[i % 3])) % 256;
        t = sStage[i]; sStage[i] = sStage[j]; sStage[j] = t;
      end
    end else if (kind == 2) begin
      for (int i = 255; i > 0; i--) begin
        r = $urandom_range(0, i);
        t = sStage[i]; sStage[i] = sStage[r]; sStage[r] = t;
      end
    end
  endtask

  task automatic clearCtPt();
    for (int a = 0; a < 256; a++) begin
      ctStage[a] = 8'h00;
      ptStage[a] = 8'((a * 7 + 3) % 256);
    end
  endtask

  // Load memories, start a run, and wait (bounded) for rdy.
  task automatic applyStimulus(input int pulseAt, output int cycles);
    @(negedge clk);
    loadReq = 1'b1;
    cntClr  = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
    cntClr  = 1'b0;
    refModel(CHECK_EN);
    en = 1'b1;
    @(negedge clk);
    en     = 1'b0;
    cycles = 1;
    while (!rdy && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      en = (cycles == pulseAt);
    end
    en = 1'b0;
    if (!rdy) checkOutput("rdy timeout", 64'(rdy), 64'd1);
  endtask

  task automatic checkAgainstModel(input string tag, input int cycles);
    int bad, firstBad;
    checkOutput({tag, " cycles"}, 64'(cycles), 64'(3 + 6 * expProcessed));
    checkOutput({tag, " invalid"}, 64'(invalid), 64'(expInv));
    checkOutput({tag, " s writes"}, 64'(sWrCnt), 64'(2 * expProcessed));
    checkOutput({tag, " pt writes"}, 64'(ptWrCnt), 64'(1 + expProcessed - int'(expInv)));
    bad = 0; firstBad = -1;
    for (int a = 0; a < 256; a++) begin
      if (ptMem[a] !== expPt[a]) begin
        bad++;
        if (firstBad < 0) firstBad = a;
      end
    end
    if (bad != 0) $display("[TB] %s first pt diff at %0d: %0h vs %0h", tag, firstBad, ptMem[firstBad], expPt[firstBad]);
    checkOutput({tag, " pt contents"}, 64'(bad), 64'd0);
    bad = 0;
    for (int a = 0; a < 256; a++) if (sMem[a] !== mS[a]) bad++;
    checkOutput({tag, " S contents"}, 64'(bad), 64'd0);
  endtask

  task automatic runTableEntry(input int idx, input int pulseAt);
    int cycles;
    string tag;
    tag = $sformatf("vec%0d/p%0d", idx, pulseAt);
    loadS(tbl[idx].keyS ? 1 : 0);
    clearCtPt();
    for (int n = 0; n < tbl[idx].nCt; n++) ctStage[n] = tbl[idx].ct[n];
    applyStimulus(pulseAt, cycles);
    checkOutput({tag, " table cycles"}, 64'(cycles), 64'(tbl[idx].cycles));
    checkOutput({tag, " table invalid"}, 64'(invalid), 64'(tbl[idx].inv));
    for (int n = 0; n < tbl[idx].nPt; n++)
      checkOutput($sformatf("%s pt[%0d]", tag, n), 64'(ptMem[n]), 64'(tbl[idx].pt[n]));
    checkAgainstModel(tag, cycles);
  endtask

  initial begin
    int cycles, len, r;
    logic [7:0] plain;

    tbl[2] = '{keyS:0, nCt:1, ct:{8'h00, {10{8'h00}}}, nPt:1, pt:{8'h00, {10{8'h00}}}, cycles:3, inv:0};
    tbl[4] = '{keyS:0, nCt:2, ct:{8'h01, 8'h63, {9{8'h00}}}, nPt:2, pt:{8'h01, 8'h61, {9{8'h00}}}, cycles:9, inv:0};
    tbl[5] = '{keyS:0, nCt:2, ct:{8'h01, 8'h22, {9{8'h00}}}, nPt:2, pt:{8'h01, 8'h20, {9{8'h00}}}, cycles:9, inv:0};
    tbl[6] = '{keyS:0, nCt:2, ct:{8'h01, 8'h78, {9{8'h00}}}, nPt:2, pt:{8'h01, 8'h7A, {9{8'h00}}}, cycles:9, inv:0};
`ifdef PRGA_VALID_CHECK_EN
    tbl[0] = '{keyS:0, nCt:2, ct:{8'h01, 8'h00, {9{8'h00}}}, nPt:1, pt:{8'h01, {10{8'h00}}}, cycles:9, inv:1};
    tbl[1] = '{keyS:0, nCt:3, ct:{8'h02, 8'h00, 8'h00, {8{8'h00}}}, nPt:1, pt:{8'h02, {10{8'h00}}}, cycles:9, inv:1};
    tbl[3] = '{keyS:1, nCt:10,
               ct:{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3, 8'h00},
               nPt:1, pt:{8'h09, {10{8'h00}}}, cycles:9, inv:1};
    tbl[7] = '{keyS:0, nCt:2, ct:{8'h01, 8'h79, {9{8'h00}}}, nPt:1, pt:{8'h01, {10{8'h00}}}, cycles:9, inv:1};
    tbl[8] = '{keyS:0, nCt:2, ct:{8'h01, 8'h62, {9{8'h00}}}, nPt:1, pt:{8'h01, {10{8'h00}}}, cycles:9, inv:1};
`else
    tbl[0] = '{keyS:0, nCt:2, ct:{8'h01, 8'h00, {9{8'h00}}}, nPt:2, pt:{8'h01, 8'h02, {9{8'h00}}}, cycles:9, inv:0};
    tbl[1] = '{keyS:0, nCt:3, ct:{8'h02, 8'h00, 8'h00, {8{8'h00}}}, nPt:3, pt:{8'h02, 8'h02, 8'h05, {8{8'h00}}}, cycles:15, inv:0};
    tbl[3] = '{keyS:1, nCt:10,
               ct:{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3, 8'h00},
               nPt:10, pt:{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74, 8'h00},
               cycles:57, inv:0};
    tbl[7] = '{keyS:0, nCt:2, ct:{8'h01, 8'h79, {9{8'h00}}}, nPt:2, pt:{8'h01, 8'h7B, {9{8'h00}}}, cycles:9, inv:0};
    tbl[8] = '{keyS:0, nCt:2, ct:{8'h01, 8'h62, {9{8'h00}}}, nPt:2, pt:{8'h01, 8'h60, {9{8'h00}}}, cycles:9, inv:0};
`endif

    rst_n   = 1'b0;
    en      = 1'b0;
    loadReq = 1'b0;
    cntClr  = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset outputs",
                {20'h0, rdy, s_wren, pt_wren, invalid, s_addr, ct_addr, pt_addr, s_din, pt_din},
                {20'h0, 1'b1, 1'b0, 1'b0, 1'b0, 40'h0});
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table vectors.
    for (int v = 0; v < 9; v++) runTableEntry(v, 0);

    // en re-pulsed mid-run must be ignored.
    runTableEntry(3, 7);
    runTableEntry(1, 12);

    // Reset asserted while the first byte is in RD_J.
    loadS(0);
    clearCtPt();
    ctStage[0] = 8'h02;
    @(negedge clk);
    loadReq = 1'b1;
    @(negedge clk);
    loadReq = 1'b0;
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("async reset outputs", {rdy, s_wren, pt_wren, s_addr, pt_addr}, {1'b1, 1'b0, 1'b0, 16'h0});
    @(negedge clk);
    checkOutput("reset next cycle", {rdy, s_wren, pt_wren}, {1'b1, 1'b0, 1'b0});
    rst_n = 1'b1;
    runTableEntry(1, 0);

    // Randomized messages against the reference model.
    for (int it = 0; it < 20; it++) begin
      loadS(2);
      clearCtPt();
      len = (it == 1) ? 255 : $urandom_range(1, 30);
      ctStage[0] = 8'(len);
      refModel(1'b0);
      for (int n = 1; n <= len; n++) ks[n] = expPt[n];
      for (int n = 1; n <= len; n++) begin
        if (it % 2 == 1) begin
          r     = $urandom_range(0, 26);
          plain = (r == 26) ? 8'h20 : 8'(8'h61 + r);
        end else begin
          plain = 8'($urandom);
        end
        ctStage[n] = ks[n] ^ plain;
      end
      if (it % 4 == 3) begin
        r = $urandom_range(1, len);
        ctStage[r] = ks[r] ^ 8'h7F;
      end
      applyStimulus(0, cycles);
      checkAgainstModel($sformatf("rand%0d len%0d", it, len), cycles);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
